// File: rtl/pipe_stage_regs.sv
// PC, F->E and E->MW pipeline registers for the 3-stage core, steered by hazard Stall/Stall_MW/Flush.
// Optional performance counters are enabled with `define PIPE_PERF_CNT_EN.
module pipe_stage_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_next_i,
  input  logic [31:0] inst_f_i,
  input  logic        reg_wr_e_i,
  input  logic [1:0]  wb_sel_e_i,
  input  logic [31:0] alu_res_e_i,
  input  logic [31:0] wdata_e_i,
  input  logic        mem_wr_e_i,
  input  logic        Stall_i,
  input  logic        Stall_MW_i,
  input  logic        Flush_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_e_o,
  output logic [31:0] inst_e_o,
  output logic [4:0]  raddr1_o,
  output logic [4:0]  raddr2_o,
  output logic [31:0] pc_MW_o,
  output logic [31:0] alu_res_MW_o,
  output logic [31:0] wdata_MW_o,
  output logic [4:0]  waddr_MW_o,
  output logic        reg_wrMW_o,
  output logic        mem_wrMW_o,
  output logic [1:0]  wb_selMW_o,
  output logic        mw_bubble_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] retire_cnt_o
);

  logic [31:0] pc_q, pc_e_q, inst_e_q;
  logic        e_bubble_q;
  logic [31:0] pc_mw_q, alu_res_mw_q, wdata_mw_q;
  logic [4:0]  waddr_mw_q;
  logic        reg_wr_mw_q, mem_wr_mw_q, mw_bubble_q;
  logic [1:0]  wb_sel_mw_q;

  // A stall freezes PC and E; any flush in that cycle is dropped and re-issued later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pc_e_q     <= '0;
      inst_e_q   <= NOP;
      e_bubble_q <= 1'b1;
    end else if (!Stall_i) begin
      pc_q   <= pc_next_i;
      pc_e_q <= pc_q;
      if (Flush_i) begin
        inst_e_q   <= NOP;
        e_bubble_q <= 1'b1;
      end else begin
        inst_e_q   <= inst_f_i;
        e_bubble_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_mw_q      <= '0;
      alu_res_mw_q <= '0;
      wdata_mw_q   <= '0;
      waddr_mw_q   <= '0;
      reg_wr_mw_q  <= 1'b0;
      mem_wr_mw_q  <= 1'b0;
      wb_sel_mw_q  <= '0;
      mw_bubble_q  <= 1'b1;
    end else if (Stall_MW_i) begin
      pc_mw_q      <= '0;
      alu_res_mw_q <= '0;
      wdata_mw_q   <= '0;
      waddr_mw_q   <= '0;
      reg_wr_mw_q  <= 1'b0;
      mem_wr_mw_q  <= 1'b0;
      wb_sel_mw_q  <= '0;
      mw_bubble_q  <= 1'b1;
    end else begin
      pc_mw_q      <= pc_e_q;
      alu_res_mw_q <= alu_res_e_i;
      wdata_mw_q   <= wdata_e_i;
      waddr_mw_q   <= inst_e_q[11:7];
      reg_wr_mw_q  <= reg_wr_e_i & ~e_bubble_q;
      mem_wr_mw_q  <= mem_wr_e_i & ~e_bubble_q;
      wb_sel_mw_q  <= wb_sel_e_i;
      mw_bubble_q  <= e_bubble_q;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, retire_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (Stall_i)             stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (Flush_i && !Stall_i) flush_cnt_q  <= flush_cnt_q + 32'd1;
      if (!mw_bubble_q)        retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign retire_cnt_o = retire_cnt_q;
`else
  assign stall_cnt_o  = '0;
  assign flush_cnt_o  = '0;
  assign retire_cnt_o = '0;
`endif

  assign pc_o         = pc_q;
  assign pc_e_o       = pc_e_q;
  assign inst_e_o     = inst_e_q;
  assign raddr1_o     = inst_e_q[19:15];
  assign raddr2_o     = inst_e_q[24:20];
  assign pc_MW_o      = pc_mw_q;
  assign alu_res_MW_o = alu_res_mw_q;
  assign wdata_MW_o   = wdata_mw_q;
  assign waddr_MW_o   = waddr_mw_q;
  assign reg_wrMW_o   = reg_wr_mw_q;
  assign mem_wrMW_o   = mem_wr_mw_q;
  assign wb_selMW_o   = wb_sel_mw_q;
  assign mw_bubble_o  = mw_bubble_q;

  // Holding E while MW advances would duplicate the E instruction.
  a_stall_implies_stall_mw : assert property (
    @(posedge clk) disable iff (!rst_n) !(Stall_i && !Stall_MW_i)
  );

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs: reset, straight-line flow, load-use stall, branch flush,
// stall+flush collision, async reset mid-run and (with PIPE_PERF_CNT_EN) the performance counters.
module tb_pipe_stage_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_next_i, inst_f_i, alu_res_e_i, wdata_e_i;
  logic        reg_wr_e_i, mem_wr_e_i, Stall_i, Stall_MW_i, Flush_i;
  logic [1:0]  wb_sel_e_i;
  logic [31:0] pc_o, pc_e_o, inst_e_o, pc_MW_o, alu_res_MW_o, wdata_MW_o;
  logic [4:0]  raddr1_o, raddr2_o, waddr_MW_o;
  logic        reg_wrMW_o, mem_wrMW_o, mw_bubble_o;
  logic [1:0]  wb_selMW_o;
  logic [31:0] stall_cnt_o, flush_cnt_o, retire_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_regs dut (
    .clk(clk), .rst_n(rst_n), .pc_next_i(pc_next_i), .inst_f_i(inst_f_i),
    .reg_wr_e_i(reg_wr_e_i), .wb_sel_e_i(wb_sel_e_i), .alu_res_e_i(alu_res_e_i),
    .wdata_e_i(wdata_e_i), .mem_wr_e_i(mem_wr_e_i), .Stall_i(Stall_i),
    .Stall_MW_i(Stall_MW_i), .Flush_i(Flush_i), .pc_o(pc_o), .pc_e_o(pc_e_o),
    .inst_e_o(inst_e_o), .raddr1_o(raddr1_o), .raddr2_o(raddr2_o), .pc_MW_o(pc_MW_o),
    .alu_res_MW_o(alu_res_MW_o), .wdata_MW_o(wdata_MW_o), .waddr_MW_o(waddr_MW_o),
    .reg_wrMW_o(reg_wrMW_o), .mem_wrMW_o(mem_wrMW_o), .wb_selMW_o(wb_selMW_o),
    .mw_bubble_o(mw_bubble_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the following falling edge.
  task automatic cyc(input logic [31:0] nxt, input logic [31:0] inst,
                     input logic st, input logic st_mw, input logic fl);
    pc_next_i  = nxt;
    inst_f_i   = inst;
    Stall_i    = st;
    Stall_MW_i = st_mw;
    Flush_i    = fl;
    @(posedge clk);
    @(negedge clk);
    Stall_i    = 1'b0;
    Stall_MW_i = 1'b0;
    Flush_i    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    pc_next_i = '0; inst_f_i = '0; alu_res_e_i = '0; wdata_e_i = '0;
    reg_wr_e_i = 1'b1; mem_wr_e_i = 1'b0; wb_sel_e_i = 2'd1;
    Stall_i = 1'b0; Stall_MW_i = 1'b0; Flush_i = 1'b0;
    @(negedge clk);
    @(negedge clk);

    check("rst_pc", pc_o, 32'h0);
    check("rst_pc_e", pc_e_o, 32'h0);
    check("rst_inst_e", inst_e_o, 32'h13);
    check("rst_mw_bubble", {31'b0, mw_bubble_o}, 32'd1);
    check("rst_reg_wr", {31'b0, reg_wrMW_o}, 32'd0);
    check("rst_waddr", {27'b0, waddr_MW_o}, 32'd0);
    check("rst_stall_cnt", stall_cnt_o, 32'd0);
    rst_n = 1'b1;

    // Straight-line code.
    cyc(32'h4, 32'h0050_0093, 1'b0, 1'b0, 1'b0);
    check("s1_pc", pc_o, 32'h4);
    check("s1_inst_e", inst_e_o, 32'h0050_0093);
    check("s1_raddr2", {27'b0, raddr2_o}, 32'd5);
    check("s1_mw_bubble", {31'b0, mw_bubble_o}, 32'd1);
    check("s1_reg_wr", {31'b0, reg_wrMW_o}, 32'd0);

    alu_res_e_i = 32'd5; wdata_e_i = 32'h55;
    cyc(32'h8, 32'h00A0_0113, 1'b0, 1'b0, 1'b0);
    check("s2_pc", pc_o, 32'h8);
    check("s2_pc_e", pc_e_o, 32'h4);
    check("s2_waddr", {27'b0, waddr_MW_o}, 32'd1);
    check("s2_reg_wr", {31'b0, reg_wrMW_o}, 32'd1);
    check("s2_mw_bubble", {31'b0, mw_bubble_o}, 32'd0);
    check("s2_alu_mw", alu_res_MW_o, 32'd5);
    check("s2_wdata_mw", wdata_MW_o, 32'h55);
    check("s2_pc_mw", pc_MW_o, 32'h0);
    check("s2_wb_sel", {30'b0, wb_selMW_o}, 32'd1);

    alu_res_e_i = 32'd10;
    cyc(32'hC, 32'h0020_8193, 1'b0, 1'b0, 1'b0);
    check("s3_pc", pc_o, 32'hC);
    check("s3_raddr1", {27'b0, raddr1_o}, 32'd1);
    check("s3_raddr2", {27'b0, raddr2_o}, 32'd2);
    check("s3_waddr", {27'b0, waddr_MW_o}, 32'd2);
    check("s3_alu_mw", alu_res_MW_o, 32'd10);
    check("s3_pc_mw", pc_MW_o, 32'h4);

    cyc(32'h10, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    check("s4_pc", pc_o, 32'h10);
    check("s4_waddr", {27'b0, waddr_MW_o}, 32'd3);

    // Load-use stall at pc 0x10.
    cyc(32'h14, 32'h1111_1111, 1'b1, 1'b1, 1'b0);
    check("lu_pc_hold", pc_o, 32'h10);
    check("lu_inst_hold", inst_e_o, 32'h0000_0013);
    check("lu_pc_e_hold", pc_e_o, 32'hC);
    check("lu_mw_bubble", {31'b0, mw_bubble_o}, 32'd1);
    check("lu_reg_wr", {31'b0, reg_wrMW_o}, 32'd0);
    check("lu_alu_zero", alu_res_MW_o, 32'd0);
    check("lu_pc_mw_zero", pc_MW_o, 32'd0);

    alu_res_e_i = 32'h77;
    cyc(32'h14, 32'h0010_0213, 1'b0, 1'b0, 1'b0);
    check("lr_pc", pc_o, 32'h14);
    check("lr_inst_e", inst_e_o, 32'h0010_0213);
    check("lr_mw_bubble", {31'b0, mw_bubble_o}, 32'd0);
    check("lr_pc_mw", pc_MW_o, 32'hC);
    check("lr_reg_wr", {31'b0, reg_wrMW_o}, 32'd1);

    // Taken branch: the instruction in E is the branch.
    cyc(32'h40, 32'h2222_2222, 1'b0, 1'b0, 1'b1);
    check("br_pc", pc_o, 32'h40);
    check("br_inst_nop", inst_e_o, 32'h13);
    check("br_pc_e", pc_e_o, 32'h14);
    check("br_mw_valid", {31'b0, mw_bubble_o}, 32'd0);
    check("br_pc_mw", pc_MW_o, 32'h10);
    check("br_waddr", {27'b0, waddr_MW_o}, 32'd4);

    mem_wr_e_i = 1'b1;
    cyc(32'h44, 32'h0030_0293, 1'b0, 1'b0, 1'b0);
    check("bb_pc", pc_o, 32'h44);
    check("bb_inst_e", inst_e_o, 32'h0030_0293);
    check("bb_mw_bubble", {31'b0, mw_bubble_o}, 32'd1);
    check("bb_reg_wr", {31'b0, reg_wrMW_o}, 32'd0);
    check("bb_mem_wr", {31'b0, mem_wrMW_o}, 32'd0);

    // Stall, Stall_MW and Flush together: no redirect.
    cyc(32'h80, 32'h3333_3333, 1'b1, 1'b1, 1'b1);
    check("sf_pc_hold", pc_o, 32'h44);
    check("sf_inst_hold", inst_e_o, 32'h0030_0293);
    check("sf_pc_e_hold", pc_e_o, 32'h40);
    check("sf_mw_bubble", {31'b0, mw_bubble_o}, 32'd1);
    check("sf_mem_wr", {31'b0, mem_wrMW_o}, 32'd0);

    reg_wr_e_i = 1'b0; wdata_e_i = 32'hDEAD; wb_sel_e_i = 2'd2;
    cyc(32'h20, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    check("st_pc", pc_o, 32'h20);
    check("st_mw_valid", {31'b0, mw_bubble_o}, 32'd0);
    check("st_mem_wr", {31'b0, mem_wrMW_o}, 32'd1);
    check("st_reg_wr", {31'b0, reg_wrMW_o}, 32'd0);
    check("st_wdata", wdata_MW_o, 32'hDEAD);
    check("st_waddr", {27'b0, waddr_MW_o}, 32'd5);
    check("st_pc_mw", pc_MW_o, 32'h40);
    check("st_wb_sel", {30'b0, wb_selMW_o}, 32'd2);

    // Asynchronous reset mid-cycle.
    mem_wr_e_i = 1'b0; reg_wr_e_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("ar_pc", pc_o, 32'h0);
    check("ar_inst_e", inst_e_o, 32'h13);
    check("ar_mw_bubble", {31'b0, mw_bubble_o}, 32'd1);
    check("ar_reg_wr", {31'b0, reg_wrMW_o}, 32'd0);
    check("ar_mem_wr", {31'b0, mem_wrMW_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter workload: 3 stalls, 2 flushes, then 12 normal cycles (10 with a valid MW).
    for (int i = 0; i < 3; i++) cyc(32'h0, 32'h13, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc(32'h0, 32'h13, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cyc(32'h0, 32'h13, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_PERF_CNT_EN
    check("cnt_stall", stall_cnt_o, 32'd3);
    check("cnt_flush", flush_cnt_o, 32'd2);
    check("cnt_retire", retire_cnt_o, 32'd10);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt_q;
    cyc(32'h0, 32'h13, 1'b0, 1'b0, 1'b0);
    check("cnt_retire_wrap", retire_cnt_o, 32'd0);
`else
    check("cnt_stall_off", stall_cnt_o, 32'd0);
    check("cnt_flush_off", flush_cnt_o, 32'd0);
    check("cnt_retire_off", retire_cnt_o, 32'd0);
`endif
    check("cnt_mw_valid", {31'b0, mw_bubble_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_regs.md
# pipe_stage_regs

Pipeline-register and PC-sequencing block for the 3-stage RISC-V core (Fetch → Execute → Memory/Writeback). It consumes the hazard unit's `Stall`, `Stall_MW` and `Flush` controls and applies them to the PC, the F→E register and the E→MW register. It also produces the MW-stage and E-stage signals the hazard unit observes: `reg_wrMW`, `wb_selMW`, `waddr_MW`, `raddr1/2` and the bubble flag that drives its `valid` input.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP`, 32'h0000_0013, instruction word inserted on flush and reset (`addi x0,x0,0`)
- `clk`  in  1  core clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pc_next_i`  in  32  next PC (pc+4 or branch/jump target) from the PC mux
- `inst_f_i`  in  32  instruction read from imem at `pc_o`
- `reg_wr_e_i`, `wb_sel_e_i[1:0]`, `alu_res_e_i[31:0]`, `wdata_e_i[31:0]`, `mem_wr_e_i`  in  —  Execute-stage results and controls from the controller/ALU
- `Stall_i`, `Stall_MW_i`, `Flush_i`  in  1 each  hazard unit controls
- `pc_o`  out  32  fetch PC
- `pc_e_o`, `inst_e_o`  out  32 each  Execute-stage PC and instruction
- `raddr1_o`, `raddr2_o`  out  5 each  `inst_e_o[19:15]`, `inst_e_o[24:20]` (combinational)
- `pc_MW_o`, `alu_res_MW_o`, `wdata_MW_o`  out  32 each  MW-stage datapath registers
- `waddr_MW_o`  out  5  MW-stage destination register
- `reg_wrMW_o`, `mem_wrMW_o`  out  1 each  MW write enables, forced to 0 for bubbles
- `wb_selMW_o`  out  2  MW write-back select
- `mw_bubble_o`  out  1  MW holds a bubble; drives hazard unit `valid`
- `stall_cnt_o`, `flush_cnt_o`, `retire_cnt_o`  out  32 each  performance counters (see Configuration)

## Operation
- Internal state: `pc`, E register {pc, inst, e_bubble}, MW register {pc, alu_res, wdata, waddr, reg_wr, mem_wr, wb_sel, mw_bubble}.
- Each edge, evaluated by priority:
  - Stall (`Stall_i`=1): `pc` and the E register hold. `Flush_i` is ignored, because a branch whose operands depend on the MW load has an invalid outcome.
  - Flush (`Flush_i`=1, `Stall_i`=0): `pc`←`pc_next_i`. E←{`pc_o`, `NOP`, e_bubble=1}.
  - Normal: `pc`←`pc_next_i`. E←{`pc_o`, `inst_f_i`, e_bubble=0}.
- MW register update:
  - If `Stall_MW_i`=1: MW loads a bubble (mw_bubble=1; reg_wr, mem_wr, waddr, wb_sel = 0; datapath fields = 0).
  - Otherwise MW loads the E results, with waddr=`inst_e_o[11:7]` and mw_bubble=e_bubble.
  - When e_bubble=1, `reg_wr` and `mem_wr` are forced to 0.
- `Stall_i`=1 with `Stall_MW_i`=0 is illegal. The block still holds E and advances MW normally, so the instruction in E is duplicated; this case is flagged by assertion.
- A flush during a stall cycle is dropped. The hazard unit re-asserts `Flush_i` when the branch re-executes.

## Timing
- Reset (async assert, sync-safe deassert):
  - `pc_o`=`RESET_PC`, `pc_e_o`=0, `inst_e_o`=`NOP`, e_bubble=1.
  - All MW outputs 0, `mw_bubble_o`=1.
  - All counters 0.
- Latency: an instruction fetched at cycle n appears in E at n+1 and in MW at n+2 (no hazards).
- Load-use stall: 1 cycle. The dependent instruction stays in E one extra cycle, and a bubble enters MW.
- Branch penalty: 1 cycle, one NOP bubble in E.
- `raddr1_o`/`raddr2_o` are purely combinational from the E register. There is no combinational path from `Stall_i`/`Flush_i` to any output.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - `stall_cnt_o` increments on each cycle with `Stall_i`=1.
  - `flush_cnt_o` increments on each cycle with `Flush_i`=1 and `Stall_i`=0.
  - `retire_cnt_o` increments on each cycle with `mw_bubble_o`=0.
  - All counters are 32-bit and wrap from FFFF_FFFF to 0.
- Not defined: counter registers are omitted and all three outputs are tied to 0.

## Test plan
- Reset mid-run: drive `rst_n`=0 asynchronously while `pc_o`=0x20 → immediately `pc_o`=0, `inst_e_o`=0x13, `mw_bubble_o`=1, `reg_wrMW_o`=0.
- Straight-line code: `pc_next_i`=`pc_o`+4, no hazards, `inst_f_i`=0x00500093 at PC 0 → `inst_e_o`=0x00500093 at cycle 1, `waddr_MW_o`=1 and `reg_wrMW_o`=1 at cycle 2, `pc_o` sequence 0,4,8.
- Load-use: `Stall_i`=`Stall_MW_i`=1 for one cycle at `pc_o`=0x10 → `pc_o` stays 0x10, `inst_e_o` unchanged, next cycle `mw_bubble_o`=1 and `reg_wrMW_o`=0, then normal flow resumes.
- Taken branch: `Flush_i`=1, `pc_next_i`=0x40 → `pc_o`=0x40, `inst_e_o`=0x13 with bubble, the branch reaches MW with `mw_bubble_o`=0, and the bubble reaches MW one cycle later.
- Simultaneous `Stall_i`=`Stall_MW_i`=`Flush_i`=1 → PC and E hold, MW bubble, no redirect to `pc_next_i`.
- With `PIPE_PERF_CNT_EN` defined: 3 stalls, 2 flushes and 10 cycles of non-bubble MW → counters read 3, 2 and 10. Preload `retire_cnt_o` to FFFF_FFFF and retire once → it reads 0.
